// File: rtl/rr_mux_sel_arbiter_4.sv
// Round-robin arbiter for four requesters driving the 4:1 mux select.
// Grants are held for up to MAX_HOLD transfers; select changes only at grant boundaries.
module rr_mux_sel_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ready,
  output logic       s1,
  output logic       s0,
  output logic [3:0] gnt,
  output logic       valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } st_t;

  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  st_t           st, st_n;
  logic [1:0]    idx, idx_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    gnt_n;
  logic [1:0]    sel_n;

  logic          xfer;
  logic          drop;
  logic          last;
  logic [3:0]    rel_req;
  logic [2:0]    idle_win;
  logic [2:0]    rel_win;

  // {found, index} of first set bit scanning up from p, wrapping mod 4
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [2:0] res;
    logic [1:0] c;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign xfer     = (st == GRANT) && ready;
  assign drop     = (st == GRANT) && !req[idx];
  assign last     = xfer && (cnt == LAST);
  assign rel_req  = drop ? (req & ~(4'b0001 << idx)) : req;
  assign idle_win = pick(req, ptr);
  assign rel_win  = pick(rel_req, idx + 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      idx <= '0;
      ptr <= '0;
      cnt <= '0;
      gnt <= '0;
      s1  <= 1'b0;
      s0  <= 1'b0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      gnt <= gnt_n;
      s1  <= sel_n[1];
      s0  <= sel_n[0];
    end
  end

  always_comb begin
    st_n  = st;
    idx_n = idx;
    ptr_n = ptr;
    cnt_n = cnt;
    unique case (st)
      IDLE: begin
        if (idle_win[2]) begin
          st_n  = GRANT;
          idx_n = idle_win[1:0];
          cnt_n = '0;
        end
      end
      GRANT: begin
        if (drop || last) begin
          ptr_n = idx + 2'd1;
          cnt_n = '0;
          if (rel_win[2]) idx_n = rel_win[1:0];
          else            st_n  = IDLE;
        end else if (xfer) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // select holds its last value while idle
  always_comb begin
    gnt_n = '0;
    sel_n = {s1, s0};
    if (st_n == GRANT) begin
      gnt_n = 4'b0001 << idx_n;
      sel_n = idx_n;
    end
  end

  assign valid = |gnt;

endmodule

// File: tb/tb_rr_mux_sel_arbiter_4.sv
// Bench for rr_mux_sel_arbiter_4: directed vector table with a scoreboard
// queue on MAX_HOLD=8 and MAX_HOLD=2 instances, then random invariant checks.
module tb_rr_mux_sel_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic       ready = 1'b0;

  logic       s1_8, s0_8, valid_8;
  logic [3:0] gnt_8;
  logic       s1_2, s0_2, valid_2;
  logic [3:0] gnt_2;

  int total = 0;
  int bad = 0;

  rr_mux_sel_arbiter_4 #(.MAX_HOLD(8), .CW(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ready (ready),
    .s1    (s1_8),
    .s0    (s0_8),
    .gnt   (gnt_8),
    .valid (valid_8)
  );

  rr_mux_sel_arbiter_4 #(.MAX_HOLD(2), .CW(4)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ready (ready),
    .s1    (s1_2),
    .s0    (s0_2),
    .gnt   (gnt_2),
    .valid (valid_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] rq;
    logic       rd;
    logic [3:0] g8;
    logic [1:0] s8;
    logic [3:0] g2;
    logic [1:0] s2;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] g8;
    logic [1:0] s8;
    logic [3:0] g2;
    logic [1:0] s2;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string nm, input int row,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, got, want);
    end
  endtask

  task automatic add(input int n, input bit rst, input logic [3:0] rq,
                     input logic rd, input logic [3:0] g8, input logic [1:0] s8,
                     input logic [3:0] g2, input logic [1:0] s2);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.rst = rst && (k == 0);
      v.rq = rq; v.rd = rd;
      v.g8 = g8; v.s8 = s8;
      v.g2 = g2; v.s2 = s2;
      vt.push_back(v);
    end
  endtask

  task automatic do_reset(input int row);
    rst_n = 1'b0;
    #1;
    chk("async_gnt8", row, gnt_8, 0);
    chk("async_val8", row, valid_8, 0);
    chk("async_sel8", row, {s1_8, s0_8}, 0);
    chk("async_gnt2", row, gnt_2, 0);
    chk("async_val2", row, valid_2, 0);
    chk("async_sel2", row, {s1_2, s0_2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  initial begin
    int i8, i2;
    exp_t e;
    logic [3:0] r;
    logic ok;

    // single requester: held, then re-granted with no bubble
    add(12, 1, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001, 2'd0);
    // rotation with all requesting
    for (int k = 0; k < 10; k++) begin
      i8 = (k < 8) ? 0 : 1;
      i2 = (k / 2) % 4;
      add(1, k == 0, 4'hF, 1'b1, oh(i8), 2'(i8), oh(i2), 2'(i2));
    end
    // backpressure then release
    add(20, 1, 4'b0011, 1'b0, 4'b0001, 2'd0, 4'b0001, 2'd0);
    for (int k = 0; k < 9; k++) begin
      i8 = (k < 7) ? 0 : 1;
      i2 = ((k + 1) / 2) % 2;
      add(1, 0, 4'b0011, 1'b1, oh(i8), 2'(i8), oh(i2), 2'(i2));
    end
    // early drop of ch2 with ch0 waiting
    add(1, 1, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    add(1, 0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    add(1, 0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0001, 2'd0);
    add(2, 0, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001, 2'd0);
    // early drop to idle: select holds
    add(1, 1, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    add(1, 0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    add(1, 0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0001, 2'd0);
    add(2, 0, 4'b0000, 1'b1, 4'b0000, 2'd2, 4'b0000, 2'd0);
    // drop moves ptr to 3, so ch3 beats ch0
    add(1, 1, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    add(1, 0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    add(1, 0, 4'b0101, 1'b1, 4'b0100, 2'd2, 4'b0001, 2'd0);
    add(1, 0, 4'b1001, 1'b1, 4'b1000, 2'd3, 4'b0001, 2'd0);
    // MAX_HOLD release on ch3 with ch0 also requesting
    add(1, 1, 4'b1000, 1'b1, 4'b1000, 2'd3, 4'b1000, 2'd3);
    for (int k = 2; k <= 17; k++) begin
      i8 = (k <= 8 || k == 17) ? 3 : 0;
      i2 = (((k - 1) / 2) % 2 == 0) ? 3 : 0;
      add(1, 0, 4'b1001, 1'b1, oh(i8), 2'(i8), oh(i2), 2'(i2));
    end
    // reset while ch2 holds the grant
    add(1, 1, 4'b0100, 1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    add(1, 1, 4'b1000, 1'b1, 4'b1000, 2'd3, 4'b1000, 2'd3);

    #2;
    foreach (vt[i]) begin
      if (vt[i].rst) do_reset(i);
      req = vt[i].rq;
      ready = vt[i].rd;
      e.row = i;
      e.g8 = vt[i].g8; e.s8 = vt[i].s8;
      e.g2 = vt[i].g2; e.s2 = vt[i].s2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", i, 1, 0);
      end else begin
        e = sb.pop_front();
        chk("gnt8", e.row, gnt_8, e.g8);
        chk("sel8", e.row, {s1_8, s0_8}, e.s8);
        chk("val8", e.row, valid_8, |e.g8);
        chk("gnt2", e.row, gnt_2, e.g2);
        chk("sel2", e.row, {s1_2, s0_2}, e.s2);
        chk("val2", e.row, valid_2, |e.g2);
      end
    end

    // random traffic: structural invariants on both instances
    for (int c = 0; c < 300; c++) begin
      r = 4'($urandom_range(0, 15));
      req = r;
      ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      ok = (valid_8 == |gnt_8) && $onehot0(gnt_8) &&
           (!valid_8 || gnt_8 == oh(int'({s1_8, s0_8}))) &&
           ((gnt_8 & ~r) == 4'b0000);
      chk("inv8", c, ok, 1);
      ok = (valid_2 == |gnt_2) && $onehot0(gnt_2) &&
           (!valid_2 || gnt_2 == oh(int'({s1_2, s0_2}))) &&
           ((gnt_2 & ~r) == 4'b0000);
      chk("inv2", c, ok, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
